// File: rtl/fp16_add_seq.sv
// fp16_add_seq: multi-cycle IEEE-754 half-precision adder/subtractor.
//
// One operand pair is accepted, then walked through ALIGN, CALC, NORM
// (one shift per cycle) and ROUND before the result is presented. Denormal
// operands are flushed to zero. NaN and inf - inf produce CANON_NAN.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, so in_valid is ignored while
// busy. out_valid is held, with out_result stable, until out_ready is seen;
// out_ready is ignored while out_valid is low.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_a, in_b          operands {sign, exp[4:0], frac[9:0]}
//   in_sub              1 = A - B, 0 = A + B
//   out_valid/out_ready result handshake
//   out_result          half-precision result
//   busy                high in every state except IDLE
module fp16_add_seq #(
    parameter logic [15:0] CANON_NAN = 16'h7E00,
    parameter int          NORM_MAX  = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_sub,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_result,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_ALIGN, S_CALC, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] a_q, a_nxt, b_q, b_nxt, result_q, result_nxt;
    logic        sub_q, sub_nxt, sign_q, sign_nxt, op_sub_q, op_sub_nxt;
    logic [5:0]  exp_q, exp_nxt;      // one spare bit to catch overflow to 31+
    logic [10:0] large_q, large_nxt;
    logic [13:0] small_q, small_nxt;
    logic [14:0] cal_q, cal_nxt;
    logic [3:0]  cnt_q, cnt_nxt;

    // ---------------- ALIGN datapath ----------------
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap;
    logic [4:0]  ea, eb, l_exp, s_exp, diff;
    logic [9:0]  fa, fb, l_frac, s_frac;
    logic [13:0] s_src, small_al;
    logic [27:0] s_ext;

    assign sa    = a_q[15];
    assign sb    = b_q[15] ^ sub_q;
    assign ea    = a_q[14:10];
    assign eb    = b_q[14:10];
    // Flush-to-zero: a zero exponent discards the fraction entirely.
    assign fa    = (ea == 5'd0) ? 10'd0 : a_q[9:0];
    assign fb    = (eb == 5'd0) ? 10'd0 : b_q[9:0];
    assign a_nan = (ea == 5'h1F) && (a_q[9:0] != 10'd0);
    assign b_nan = (eb == 5'h1F) && (b_q[9:0] != 10'd0);
    assign a_inf = (ea == 5'h1F) && (a_q[9:0] == 10'd0);
    assign b_inf = (eb == 5'h1F) && (b_q[9:0] == 10'd0);
    assign swap  = {eb, fb} > {ea, fa};
    assign l_exp  = swap ? eb : ea;
    assign l_frac = swap ? fb : fa;
    assign s_exp  = swap ? ea : eb;
    assign s_frac = swap ? fa : fb;
    assign diff   = l_exp - s_exp;
    assign s_src  = {s_exp != 5'd0, s_frac, 3'b000};
    // Shift into a double-width window so the lost bits can be ORed as sticky.
    assign s_ext  = {s_src, 14'd0} >> diff;
    assign small_al = (diff >= 5'd14) ? {13'd0, |s_src}
                                      : (s_ext[27:14] | {13'd0, |s_ext[13:0]});

    // ---------------- CALC / NORM / ROUND datapath ----------------
    logic [14:0] cal_sum, cal_r, cal_l;
    logic [10:0] mant;
    logic [11:0] mant_sum;
    logic        rnd_inc;
    logic [5:0]  rnd_exp;
    logic [10:0] rnd_mant;

    assign cal_sum = op_sub_q ? ({1'b0, large_q, 3'b000} - {1'b0, small_q})
                              : ({1'b0, large_q, 3'b000} + {1'b0, small_q});
    // Right shift keeps the dropped bit alive in the sticky position.
    assign cal_r    = {1'b0, cal_q[14:1]} | {14'd0, cal_q[0]};
    assign cal_l    = {cal_q[13:0], 1'b0};
    assign mant     = cal_q[13:3];
    assign rnd_inc  = cal_q[2] & (cal_q[1] | cal_q[0] | cal_q[3]);
    assign mant_sum = {1'b0, mant} + {11'd0, rnd_inc};
    assign rnd_exp  = exp_q + {5'd0, mant_sum[11]};
    assign rnd_mant = mant_sum[11] ? 11'h400 : mant_sum[10:0];

    // ---------------- FSM: next state and datapath updates ----------------
    always_comb begin
        state_nxt  = state;
        a_nxt      = a_q;
        b_nxt      = b_q;
        sub_nxt    = sub_q;
        sign_nxt   = sign_q;
        op_sub_nxt = op_sub_q;
        exp_nxt    = exp_q;
        large_nxt  = large_q;
        small_nxt  = small_q;
        cal_nxt    = cal_q;
        cnt_nxt    = cnt_q;
        result_nxt = result_q;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    a_nxt     = in_a;
                    b_nxt     = in_b;
                    sub_nxt   = in_sub;
                    state_nxt = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
                    result_nxt = CANON_NAN;
                    state_nxt  = S_DONE;
                end else if (a_inf) begin
                    result_nxt = {sa, 5'h1F, 10'd0};
                    state_nxt  = S_DONE;
                end else if (b_inf) begin
                    result_nxt = {sb, 5'h1F, 10'd0};
                    state_nxt  = S_DONE;
                end else begin
                    sign_nxt   = swap ? sb : sa;
                    op_sub_nxt = (sa != sb);
                    exp_nxt    = {1'b0, l_exp};
                    large_nxt  = {l_exp != 5'd0, l_frac};
                    small_nxt  = small_al;
                    state_nxt  = S_CALC;
                end
            end
            S_CALC: begin
                cnt_nxt = 4'd0;
                if (cal_sum == 15'd0) begin
                    // Exact cancellation gives +0; only -0 + -0 stays negative.
                    result_nxt = (!op_sub_q && sign_q) ? 16'h8000 : 16'h0000;
                    state_nxt  = S_DONE;
                end else begin
                    cal_nxt   = cal_sum;
                    state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                if (cal_q[14]) begin
                    cal_nxt   = cal_r;
                    exp_nxt   = exp_q + 6'd1;
                    state_nxt = S_ROUND;
                end else if (cal_q[13]) begin
                    state_nxt = S_ROUND;
                end else begin
                    cal_nxt = cal_l;
                    exp_nxt = exp_q - 6'd1;
                    cnt_nxt = cnt_q + 4'd1;
                    if (exp_q == 6'd1) begin
                        // Would go denormal: flush to signed zero.
                        result_nxt = {sign_q, 15'd0};
                        state_nxt  = S_DONE;
                    end else if (cal_q[12]) begin
                        // This shift normalises; move on without a check cycle.
                        state_nxt = S_ROUND;
                    end else if (int'(cnt_q) + 1 >= NORM_MAX) begin
                        result_nxt = {sign_q, 15'd0};
                        state_nxt  = S_DONE;
                    end
                end
            end
            S_ROUND: begin
                if (rnd_exp >= 6'd31) result_nxt = {sign_q, 5'h1F, 10'd0};
                else                  result_nxt = {sign_q, rnd_exp[4:0], rnd_mant[9:0]};
                state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            a_q      <= 16'd0;
            b_q      <= 16'd0;
            sub_q    <= 1'b0;
            sign_q   <= 1'b0;
            op_sub_q <= 1'b0;
            exp_q    <= 6'd0;
            large_q  <= 11'd0;
            small_q  <= 14'd0;
            cal_q    <= 15'd0;
            cnt_q    <= 4'd0;
            result_q <= 16'd0;
        end else begin
            state    <= state_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            sub_q    <= sub_nxt;
            sign_q   <= sign_nxt;
            op_sub_q <= op_sub_nxt;
            exp_q    <= exp_nxt;
            large_q  <= large_nxt;
            small_q  <= small_nxt;
            cal_q    <= cal_nxt;
            cnt_q    <= cnt_nxt;
            result_q <= result_nxt;
        end
    end

    assign in_ready   = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign out_valid  = (state == S_DONE);
    assign out_result = result_q;

endmodule

// File: tb/tb_fp16_add_seq.sv
// Testbench for fp16_add_seq: directed cases with fixed expected values and
// latencies, randomized operands checked against an exact-arithmetic model,
// output backpressure and an asynchronous reset abort.
module tb_fp16_add_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    fp16_add_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_sub     (in_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Operands become exact integers in units of 2^-24, are summed exactly,
    // then rounded to nearest-even; results below the normal range flush.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b,
                                            input logic sub);
        logic   sa, sb, sign;
        int     ea, eb, p, e, sh;
        longint ma, mb, s, m, q, rem, half;
        sa = a[15];
        sb = b[15] ^ sub;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) return 16'h7E00;
        if (ea == 31 && eb == 31) return (sa != sb) ? 16'h7E00 : {sa, 15'h7C00};
        if (ea == 31) return {sa, 15'h7C00};
        if (eb == 31) return {sb, 15'h7C00};
        ma = (ea == 0) ? 0 : (longint'({1'b1, a[9:0]}) << (ea - 1));
        mb = (eb == 0) ? 0 : (longint'({1'b1, b[9:0]}) << (eb - 1));
        s  = (sa ? -ma : ma) + (sb ? -mb : mb);
        if (s == 0) return (ma == 0 && mb == 0 && sa && sb) ? 16'h8000 : 16'h0000;
        sign = (s < 0);
        m    = sign ? -s : s;
        p    = 0;
        for (int i = 0; i < 62; i++) if (m[i]) p = i;
        e = p - 9;
        if (e < 1) return {sign, 15'd0};
        if (p > 10) begin
            sh   = p - 10;
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end else begin
            q = m << (10 - p);
        end
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) return {sign, 15'h7C00};
        return {sign, 5'(e), q[9:0]};
    endfunction

    // ---------------- driver / collector ----------------
    // Called at posedge+1 with the DUT idle. exp_lat <= 0 skips the latency
    // check; hold is the number of cycles out_ready stays low once valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [15:0] exp_val, input int exp_lat, input int hold);
        logic [15:0] want;
        int          lat;
        logic        seen;
        exp_q.push_back(exp_val);
        chk("in_ready_idle", in_ready, 1);
        in_a      = a;
        in_b      = b;
        in_sub    = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            // Garbage on the input side while busy must be ignored.
            in_valid = 1'($urandom_range(0, 1));
            in_a     = 16'($urandom);
            in_b     = 16'($urandom);
            in_sub   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1)) & ~out_valid;
            if (out_valid) seen = 1'b1;
        end
        in_valid = 1'b0;
        want = exp_q.pop_front();
        chk("out_valid_timeout", seen, 1);
        if (!seen) return;
        if (exp_lat > 0) chk("latency", lat, exp_lat);
        chk("result", out_result, want);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_result", out_result, want);
            chk("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 16'd0;
        in_b      = 16'd0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 16'h0000);
        chk("rst_busy", busy, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(16'h3C00, 16'h3C00, 1'b0, 16'h4000, 5, 0);
        run_op(16'h3C01, 16'h3C00, 1'b1, 16'h1400, 14, 0);
        run_op(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 5, 0);
        run_op(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 5, 0);
        run_op(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 5, 0);
        run_op(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 2, 0);
        run_op(16'h7E01, 16'h3C00, 1'b0, 16'h7E00, 2, 0);
        run_op(16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 2, 0);
        run_op(16'h8000, 16'h8000, 1'b0, 16'h8000, 3, 0);
        run_op(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 3, 5);
        run_op(16'h0400, 16'h03FF, 1'b0, 16'h0400, 5, 0);
        run_op(16'h3C00, 16'hC000, 1'b0, 16'hBC00, 0, 2);

        // Async reset during normalisation: operation is abandoned.
        chk("in_ready_pre_abort", in_ready, 1);
        in_a     = 16'h3C01;
        in_b     = 16'h3C00;
        in_sub   = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("busy_in_norm", busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk("abort_no_result", out_valid, 0);
        run_op(16'h4000, 16'h4000, 1'b0, 16'h4400, 5, 0);

        // Randomized operands against the model
        for (int n = 0; n < 250; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) rb[14:10] = ra[14:10] ^ 5'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) rb[14:0] = ra[14:0];
            run_op(ra, rb, rs, ref_add(ra, rb, rs), 0, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp16_add_seq.md
Name: fp16_add_seq

Overview:
- Multi-cycle sequencer for IEEE-754 half-precision add/subtract.
- Accepts one operand pair through a valid/ready handshake.
- Runs unpack/align, fraction add/sub, iterative normalisation and round-to-nearest-even as FSM states around a 15-bit fraction datapath: 11-bit large fraction, 14-bit aligned small fraction with G/R/S bits.
- Presents one 16-bit result on an output valid/ready handshake.
- Sits between the register-file/issue logic and writeback in the 16-bit FP unit.

Parameters:
- CANON_NAN, 16'h7E00, result pattern for any NaN or invalid (inf - inf) operation.
- NORM_MAX, 11, maximum left-shift iterations in NORM before forcing the result to zero (guards against a stuck loop).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  16  operand A {sign, exp[4:0], frac[9:0]}.
- in_b  in  16  operand B.
- in_sub  in  1  1 = A - B, 0 = A + B.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_result  out  16  half-precision result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state = IDLE; out_valid = 0, out_result = 16'h0000, busy = 0, in_ready = 1. Async assertion mid-operation aborts the operation; no result is produced.
- Capture: on in_valid & in_ready in IDLE, latch a, b and sub. Effective sign of b = b.sign ^ sub. Go to ALIGN.
- Denormals: exp == 0 operands are treated as zero (flush-to-zero).
- Hidden bit: 1 for normal operands.
- ALIGN (1 cycle):
  - Specials first: NaN in, or inf - inf (opposite effective signs) → CANON_NAN. Any other inf → that inf with its effective sign. Specials go directly to DONE.
  - Otherwise swap so that large has the greater {exp, frac}.
  - diff = exp_large - exp_small.
  - small_frac14 = {hid, frac, 3'b000} >> diff; all shifted-out bits OR into bit0 (sticky).
  - If diff >= 14, small_frac14 = 14'd1 if the small operand is nonzero, else 0.
  - Result sign = sign of large; op_sub = (sign_a != eff_sign_b).
- CALC (1 cycle):
  - cal[14:0] = {1'b0, large_frac11, 3'b000} ± {1'b0, small_frac14}, unsigned 15-bit.
  - cal == 0 → result = 16'h0000 (+0), go to DONE. Exception: both operands -0 with op_sub = 0 gives 16'h8000.
- NORM (1 cycle per step):
  - If cal[14]: one cycle, shift right 1, bit0 |= shifted-out bit, exp += 1.
  - Else, while cal[13] == 0: shift left 1, exp -= 1.
  - Exp reaching 0 during the left loop, or NORM_MAX iterations done → flush result to signed zero, go to DONE.
  - Leave NORM when cal[13] == 1.
- ROUND (1 cycle):
  - mant = cal[13:3], G = cal[2], R = cal[1], S = cal[0], L = cal[3].
  - Increment mant if G & (R | S | L).
  - Mant carry-out → mant = 11'h400, exp += 1.
  - exp >= 31 → inf {sign, 5'h1F, 10'h0}.
  - Else result = {sign, exp[4:0], mant[9:0]}.
- DONE: out_valid = 1 and out_result stable. On out_ready, go to IDLE with out_valid = 0 the next cycle. There is no new accept in that same cycle, since in_ready is only high in IDLE.
- Latency, accept to out_valid:
  - Normal path: 4 + N cycles, where N = number of NORM cycles (≥1; a cycle is spent in NORM even when already normalised).
  - Specials: 2 cycles.
  - Zero result: 3 cycles.
- Simultaneous events: in_valid is ignored outside IDLE. out_ready is ignored when out_valid = 0.

Test Plan:
- 3C00 + 3C00, sub=0 → out_result 4000 (1.0+1.0=2.0); latency 5 cycles.
- 3C01 - 3C00, sub=1 → 1400 (2^-10); NORM takes 10 left-shift cycles; latency 14.
- Tie-to-even: 3C00 + 1000 → 3C00; 3C01 + 1000 → 3C02.
- Overflow and specials: 7BFF + 7BFF → 7C00. 7C00 - 7C00 (sub=1) → 7E00. 7E01 + 3C00 → 7E00; latency 2.
- Zero and backpressure: 3C00 - 3C00 → 0000. Hold out_ready=0 for 5 cycles → out_valid and out_result stable, in_ready=0 throughout; raise out_ready → in_ready=1 next cycle.
- Async reset asserted during NORM of case 2 → out_valid=0, busy=0 immediately. After release, 4000 + 4000 → 4400.
